// File: rtl/volume_scaler_if.sv
// rtl/volume_scaler_if.sv - sample stream handshake bundle for volume_scaler
interface volume_scaler_if;
  logic signed [15:0] Sample_in;
  logic               In_valid;
  logic               In_ready;
  logic signed [15:0] Sample_out;
  logic               Out_valid;
  logic               Out_ready;

  modport master (
    output Sample_in, In_valid, Out_ready,
    input  In_ready, Sample_out, Out_valid
  );

  modport slave (
    input  Sample_in, In_valid, Out_ready,
    output In_ready, Sample_out, Out_valid
  );
endinterface

// File: rtl/volume_scaler.sv
// rtl/volume_scaler.sv - thermometer-coded volume with per-sample gain ramp and 2-stage scaling pipe
module volume_scaler #(
  parameter int RAMP_STEP = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [7:0]       Vol_level,
  volume_scaler_if.slave   bus,
  output logic [8:0]       Gain,
  output logic             Ramping
);
  typedef enum logic [1:0] {STEADY, RAMP_UP, RAMP_DOWN} state_t;

  localparam logic [9:0] STEP = 10'(RAMP_STEP);

  state_t             state;
  logic [8:0]         target;
  logic               lvl_valid;
  logic [8:0]         lvl_gain;
  logic               accept;
  logic [9:0]         up_sum;
  logic [8:0]         up_gain;
  logic [8:0]         dn_gain;

  logic               s1_valid;
  logic signed [24:0] s1_prod;
  logic               s2_valid;
  logic signed [15:0] s2_data;
  logic signed [25:0] prod_full;
  logic signed [24:0] prod_shift;
  logic               unused_bits;

  always_comb begin
    lvl_valid = 1'b1;
    lvl_gain  = 9'd0;
    case (Vol_level[3:0])
      4'b0000: lvl_gain = 9'd0;
      4'b0001: lvl_gain = 9'd64;
      4'b0011: lvl_gain = 9'd128;
      4'b0111: lvl_gain = 9'd192;
      4'b1111: lvl_gain = 9'd256;
      default: lvl_valid = 1'b0;
    endcase
  end

  assign accept = bus.In_valid && bus.In_ready;

  // Each step saturates at the target so the ramp never overshoots.
  assign up_sum  = {1'b0, Gain} + STEP;
  assign up_gain = (up_sum >= {1'b0, target}) ? target : up_sum[8:0];
  assign dn_gain = ({1'b0, Gain} <= ({1'b0, target} + STEP)) ? target : (Gain - STEP[8:0]);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      target  <= 9'd0;
      Gain    <= 9'd0;
      state   <= STEADY;
      Ramping <= 1'b0;
    end else begin
      if (lvl_valid) target <= lvl_gain;
      case (state)
        STEADY: begin
          if (target > Gain) begin
            state   <= RAMP_UP;
            Ramping <= 1'b1;
          end else if (target < Gain) begin
            state   <= RAMP_DOWN;
            Ramping <= 1'b1;
          end
        end
        RAMP_UP: begin
          if (target < Gain) begin
            state <= RAMP_DOWN;
          end else if (target == Gain) begin
            state   <= STEADY;
            Ramping <= 1'b0;
          end else if (accept) begin
            Gain <= up_gain;
            if (up_gain == target) begin
              state   <= STEADY;
              Ramping <= 1'b0;
            end
          end
        end
        RAMP_DOWN: begin
          if (target > Gain) begin
            state <= RAMP_UP;
          end else if (target == Gain) begin
            state   <= STEADY;
            Ramping <= 1'b0;
          end else if (accept) begin
            Gain <= dn_gain;
            if (dn_gain == target) begin
              state   <= STEADY;
              Ramping <= 1'b0;
            end
          end
        end
        default: begin
          state   <= STEADY;
          Ramping <= 1'b0;
        end
      endcase
    end
  end

  // Gain is at most 256, so the shifted product always fits back in 16 bits.
  assign prod_full  = $signed(bus.Sample_in) * $signed({1'b0, Gain});
  assign prod_shift = s1_prod >>> 8;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (bus.In_ready) begin
      s1_valid <= accept;
      s1_prod  <= prod_full[24:0];
      s2_valid <= s1_valid;
      s2_data  <= prod_shift[15:0];
    end
  end

  assign bus.In_ready   = Reset && (!s2_valid || bus.Out_ready);
  assign bus.Out_valid  = s2_valid;
  assign bus.Sample_out = s2_data;

  assign unused_bits = ^{prod_full[25], prod_shift[24:16], Vol_level[7:4]};
endmodule

// File: tb/tb_volume_scaler.sv
// tb/tb_volume_scaler.sv - table and scoreboard bench for volume_scaler
module tb_volume_scaler;
  logic       Clk = 1'b0;
  logic       Reset;
  logic [7:0] Vol_level;
  logic [8:0] Gain;
  logic       Ramping;

  volume_scaler_if bus();

  volume_scaler #(.RAMP_STEP(4)) dut (
    .Clk(Clk), .Reset(Reset), .Vol_level(Vol_level),
    .bus(bus), .Gain(Gain), .Ramping(Ramping)
  );

  always #5 Clk = ~Clk;

  typedef enum int {M_STEADY, M_UP, M_DOWN} mstate_t;
  typedef struct {
    logic [7:0] vol;
    int         sample;
    int         exp_gain;
    int         exp_out;
    string      name;
  } vec_t;

  int      checks = 0;
  int      errors = 0;
  int      m_tgt, m_gain;
  mstate_t m_st;
  bit      m_s1v, m_s2v;
  int      sb[$];
  int      n_acc, n_out;
  bit      last_acc, last_dut_ready;
  vec_t    vecs[11];
  int      cnt, stalls, stale;
  bit      saw_ramp, first_done, pre;

  task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive(input bit v, input int s, input bit ordy);
    bus.In_valid  = v;
    bus.Sample_in = 16'(s);
    bus.Out_ready = ordy;
  endtask

  task automatic reset_model();
    m_tgt = 0; m_gain = 0; m_st = M_STEADY; m_s1v = 0; m_s2v = 0;
    sb.delete();
  endtask

  function automatic void decode(input logic [3:0] v, output bit lv, output int g);
    lv = 1'b1; g = 0;
    case (v)
      4'b0000: g = 0;
      4'b0001: g = 64;
      4'b0011: g = 128;
      4'b0111: g = 192;
      4'b1111: g = 256;
      default: lv = 1'b0;
    endcase
  endfunction

  // One clock: check handshake, score outputs, advance the reference model.
  task automatic cycle();
    bit m_ready, acc, held, lv;
    int nt;
    logic signed [15:0] hold_val;
    #1;
    m_ready = !m_s2v || bus.Out_ready;
    last_dut_ready = bus.In_ready;
    chk("in_ready", bus.In_ready, m_ready);
    acc = bus.In_valid && m_ready;
    last_acc = acc;
    if (acc) begin
      sb.push_back((int'(bus.Sample_in) * m_gain) >>> 8);
      n_acc++;
    end
    if (bus.Out_valid && bus.Out_ready) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else chk("sample_out", bus.Sample_out, sb.pop_front());
      n_out++;
    end
    held = bus.Out_valid && !bus.Out_ready;
    hold_val = bus.Sample_out;
    decode(Vol_level[3:0], lv, nt);
    @(posedge Clk);
    case (m_st)
      M_STEADY: begin
        if (m_tgt > m_gain) m_st = M_UP;
        else if (m_tgt < m_gain) m_st = M_DOWN;
      end
      M_UP: begin
        if (m_tgt < m_gain) m_st = M_DOWN;
        else if (m_tgt == m_gain) m_st = M_STEADY;
        else if (acc) begin
          m_gain = (m_gain + 4 > m_tgt) ? m_tgt : m_gain + 4;
          if (m_gain == m_tgt) m_st = M_STEADY;
        end
      end
      default: begin
        if (m_tgt > m_gain) m_st = M_UP;
        else if (m_tgt == m_gain) m_st = M_STEADY;
        else if (acc) begin
          m_gain = (m_gain - 4 < m_tgt) ? m_tgt : m_gain - 4;
          if (m_gain == m_tgt) m_st = M_STEADY;
        end
      end
    endcase
    if (lv) m_tgt = nt;
    if (m_ready) begin
      m_s2v = m_s1v;
      m_s1v = acc;
    end
    @(negedge Clk);
    chk("gain", Gain, m_gain);
    chk("ramping", Ramping, m_st != M_STEADY);
    chk("out_valid", bus.Out_valid, m_s2v);
    if (held) chk("hold", bus.Sample_out, hold_val);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{8'h0F,   1000, 256,   1000, "unity"};
    vecs[1]  = '{8'h0F, -32768, 256, -32768, "unity_min"};
    vecs[2]  = '{8'h0F,  32767, 256,  32767, "unity_max"};
    vecs[3]  = '{8'h01,     -3,  64,     -1, "trunc_neg3"};
    vecs[4]  = '{8'h01,      5,  64,      1, "trunc_pos5"};
    vecs[5]  = '{8'h01,     -1,  64,     -1, "trunc_neg1"};
    vecs[6]  = '{8'h03,   1000, 128,    500, "half"};
    vecs[7]  = '{8'h03, -32768, 128, -16384, "half_min"};
    vecs[8]  = '{8'h07,   -101, 192,    -76, "q3_neg"};
    vecs[9]  = '{8'h07,    100, 192,     75, "q3_pos"};
    vecs[10] = '{8'h00,   1234,   0,      0, "mute"};

    Reset = 1'b0; Vol_level = 8'h00; drive(0, 0, 1);
    reset_model(); n_acc = 0; n_out = 0;
    repeat (3) @(negedge Clk);
    chk("reset_gain", Gain, 0);
    chk("reset_out_valid", bus.Out_valid, 0);
    chk("reset_in_ready", bus.In_ready, 0);
    chk("reset_ramping", Ramping, 0);
    chk("reset_sample_out", bus.Sample_out, 0);
    Reset = 1'b1;
    #1 chk("in_ready_after_reset", bus.In_ready, 1);

    // Ramp 0 -> 64 must take exactly 16 accepts.
    Vol_level = 8'h01;
    cnt = 0; saw_ramp = 0; first_done = 0;
    for (int i = 0; i < 40; i++) begin
      drive(1, i * 100 - 1500, 1);
      pre = Ramping;
      cycle();
      if (pre && last_acc) cnt++;
      if (cnt == 1 && !first_done) begin
        chk("ramp_first_step", Gain, 4);
        first_done = 1;
      end
      if (Ramping) saw_ramp = 1;
      if (saw_ramp && !Ramping) break;
    end
    chk("ramp_seen", saw_ramp, 1);
    chk("ramp_accepts", cnt, 16);
    chk("ramp_final_gain", Gain, 64);
    chk("ramp_done", Ramping, 0);

    for (int k = 0; k < 11; k++) begin
      Vol_level = vecs[k].vol;
      drive(1, 0, 1);
      repeat (80) cycle();
      drive(1, vecs[k].sample, 1);
      cycle();
      drive(0, 0, 1);
      cycle();
      chk({vecs[k].name, "_valid"}, bus.Out_valid, 1);
      chk({vecs[k].name, "_out"}, bus.Sample_out, vecs[k].exp_out);
      chk({vecs[k].name, "_gain"}, Gain, vecs[k].exp_gain);
    end

    // Backpressure: 5 stalled cycles on a continuous stream.
    Vol_level = 8'h01;
    drive(1, 0, 1);
    repeat (80) cycle();
    drive(0, 0, 1);
    repeat (3) cycle();
    n_acc = 0; n_out = 0; stalls = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1, 1000 + i * 7, !(i >= 3 && i < 8));
      cycle();
      if (!last_dut_ready) stalls++;
    end
    drive(0, 0, 1);
    repeat (4) cycle();
    chk("bp_stall_cycles", stalls, 5);
    chk("bp_drained", sb.size(), 0);
    chk("bp_count", n_out, n_acc);
    chk("bp_accepts", n_acc, 10);

    // Invalid thermometer code leaves the target alone.
    Vol_level = 8'h05;
    drive(1, 55, 1);
    repeat (6) cycle();
    chk("invalid_gain", Gain, 64);
    chk("invalid_ramping", Ramping, 0);

    // Direction reversal mid-ramp.
    Vol_level = 8'h00;
    repeat (40) cycle();
    chk("rev_start", Gain, 0);
    Vol_level = 8'h0F;
    for (int i = 0; i < 60 && m_gain != 100; i++) cycle();
    chk("rev_reach", Gain, 100);
    drive(0, 0, 1);
    Vol_level = 8'h01;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rev_no_steady", Ramping, 1);
    end
    chk("rev_hold_gain", Gain, 100);
    cnt = 0;
    for (int i = 0; i < 30 && Gain != 64; i++) begin
      drive(1, 300 - i, 1);
      pre = Ramping;
      cycle();
      if (pre && last_acc) cnt++;
    end
    chk("rev_gain", Gain, 64);
    chk("rev_accepts", cnt, 9);
    chk("rev_done", Ramping, 0);

    // Reset mid-ramp with data in flight.
    Vol_level = 8'h0F;
    drive(1, 4000, 1);
    for (int i = 0; i < 40 && m_gain != 120; i++) cycle();
    chk("rst_gain_pre", Gain, 120);
    chk("rst_inflight", bus.Out_valid, 1);
    #2 Reset = 1'b0;
    Vol_level = 8'h00;
    #1;
    chk("rst_gain", Gain, 0);
    chk("rst_out_valid", bus.Out_valid, 0);
    chk("rst_in_ready", bus.In_ready, 0);
    chk("rst_ramping", Ramping, 0);
    chk("rst_sample_out", bus.Sample_out, 0);
    reset_model();
    @(negedge Clk);
    Reset = 1'b1;
    drive(0, 0, 1);
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (bus.Out_valid) stale++;
    end
    chk("rst_no_stale", stale, 0);
    chk("rst_gain_after", Gain, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
